// File: rtl/serial_compare_ctrl.sv
// Multi-cycle WIDTH-bit unsigned magnitude compare built on one shared 2-bit slice comparator.
// Walks slices MSB-first and stops at the first unequal slice; result is one-hot aeb/agb/alb.
module serial_compare_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             aeb,
   output logic             agb,
   output logic             alb
);

   localparam int unsigned K     = WIDTH / 2;
   localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   ra;
   logic [WIDTH-1:0]   rb;
   logic [IDX_W-1:0]   idx;
   logic [1:0]         sa_c;
   logic [1:0]         sb_c;
   logic               slice_gt_c;
   logic               slice_lt_c;

   // Mux the current 2-bit slice of each captured operand onto the shared comparator
   always_comb begin
      sa_c = '0;
      sb_c = '0;
      for (int k = 0; k < int'(K); k++) begin
         if (idx == IDX_W'(k)) begin
            sa_c = ra[2*k +: 2];
            sb_c = rb[2*k +: 2];
         end
      end
   end

   assign slice_gt_c = (sa_c[1] & ~sb_c[1]) | ((sa_c[1] ~^ sb_c[1]) & sa_c[0] & ~sb_c[0]);
   assign slice_lt_c = (~sa_c[1] & sb_c[1]) | ((sa_c[1] ~^ sb_c[1]) & ~sa_c[0] & sb_c[0]);

   // Sequencer; results only change on a completion edge so they hold across the next job
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ra    <= '0;
         rb    <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         aeb   <= 1'b0;
         agb   <= 1'b0;
         alb   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  idx   <= IDX_W'(K - 1);
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (slice_gt_c || slice_lt_c) begin
                  aeb   <= 1'b0;
                  agb   <= slice_gt_c;
                  alb   <= slice_lt_c;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (idx == '0) begin
                  aeb   <= 1'b1;
                  agb   <= 1'b0;
                  alb   <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: WIDTH=8 instance for the main cases, WIDTH=2 instance
// for the single-slice case. Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_compare_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic       aeb;
   logic       agb;
   logic       alb;

   logic       start2;
   logic [1:0] a2;
   logic [1:0] b2;
   logic       busy2;
   logic       done2;
   logic       aeb2;
   logic       agb2;
   logic       alb2;

   int         vectors;
   int         miscompares;
   logic [2:0] old_res;

   serial_compare_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .aeb(aeb), .agb(agb), .alb(alb)
   );

   serial_compare_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .aeb(aeb2), .agb(agb2), .alb(alb2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One start pulse; checks busy/done timing for j slices and the one-hot result {aeb,agb,alb}
   task automatic job(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input int j, input logic [2:0] res);
      @(negedge clk);
      a = va; b = vb; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = ~va; b = ~vb;
      check({tag, " busy@E0"}, 32'(busy), 32'd1);
      check({tag, " done@E0"}, 32'(done), 32'd0);
      check({tag, " hold@E0"}, 32'({aeb, agb, alb}), 32'(old_res));
      for (int i = 1; i <= j; i++) begin
         @(negedge clk);
         if (i < j) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done early"}, 32'(done), 32'd0);
            start = 1'b1; a = 8'($urandom); b = 8'($urandom);
         end else begin
            start = 1'b0;
            check({tag, " done"}, 32'(done), 32'd1);
            check({tag, " busy@done"}, 32'(busy), 32'd0);
            check({tag, " result"}, 32'({aeb, agb, alb}), 32'(res));
         end
      end
      old_res = res;
      @(negedge clk);
      check({tag, " done fall"}, 32'(done), 32'd0);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " result hold"}, 32'({aeb, agb, alb}), 32'(res));
   endtask

   initial begin
      logic [7:0] pa [3];
      logic [7:0] pb [3];
      int         pj [3];
      logic [2:0] pr [3];
      int         cnt;

      vectors = 0; miscompares = 0; old_res = 3'b000;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      start2 = 1'b0; a2 = '0; b2 = '0;
      #12;
      check("reset outs", 32'({busy, done, aeb, agb, alb}), 32'd0);
      check("reset outs w2", 32'({busy2, done2, aeb2, agb2, alb2}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset results", 32'({aeb, agb, alb}), 32'd0);

      job("t1 A5=A5", 8'hA5, 8'hA5, 4, 3'b100);
      job("t2 80>7F", 8'h80, 8'h7F, 1, 3'b010);
      job("t3 12<13", 8'h12, 8'h13, 4, 3'b001);

      // start held high; operands scrambled while running, next pair presented at done
      pa[0] = 8'h3C; pb[0] = 8'h3C; pj[0] = 4; pr[0] = 3'b100;
      pa[1] = 8'hC0; pb[1] = 8'h40; pj[1] = 1; pr[1] = 3'b010;
      pa[2] = 8'h04; pb[2] = 8'h08; pj[2] = 3; pr[2] = 3'b001;
      @(negedge clk);
      a = pa[0]; b = pb[0]; start = 1'b1;
      for (int p = 0; p < 3; p++) begin
         cnt = 0;
         while (!busy && cnt < 4) begin
            @(negedge clk);
            cnt++;
         end
         check("t4 accept", 32'(busy), 32'd1);
         cnt = 0;
         while (!done && cnt < 10) begin
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            cnt++;
         end
         check("t4 latency", 32'(cnt), 32'(pj[p]));
         check("t4 result", 32'({aeb, agb, alb}), 32'(pr[p]));
         if (p < 2) begin
            a = pa[p+1]; b = pb[p+1];
         end
      end
      start = 1'b0;
      old_res = pr[2];
      repeat (2) @(negedge clk);
      check("t4 idle", 32'({busy, done}), 32'd0);

      // asynchronous reset in the middle of a running job
      @(negedge clk);
      a = 8'h12; b = 8'h13; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t5 reset busy/done", 32'({busy, done}), 32'd0);
      check("t5 reset results", 32'({aeb, agb, alb}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5 no done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      old_res = 3'b000;
      job("t5 01<02", 8'h01, 8'h02, 4, 3'b001);

      // single-slice instance
      @(negedge clk);
      a2 = 2'b10; b2 = 2'b11; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      check("t6 busy", 32'(busy2), 32'd1);
      @(negedge clk);
      check("t6 done", 32'(done2), 32'd1);
      check("t6 10<11", 32'({aeb2, agb2, alb2}), 32'd1);
      @(negedge clk);
      check("t6 done fall", 32'(done2), 32'd0);
      a2 = 2'b11; b2 = 2'b11; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      check("t6 hold", 32'({aeb2, agb2, alb2}), 32'd1);
      @(negedge clk);
      check("t6 done2", 32'(done2), 32'd1);
      check("t6 11=11", 32'({aeb2, agb2, alb2}), 32'd4);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
